// File: rtl/scc_mem_pkg.sv
// rtl/scc_mem_pkg.sv - shared types, widths and address helper for the SCC unified memory
package scc_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } mem_state_e;

    localparam int WORD_W     = 32;
    localparam int DEF_ADDR_W = 10;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr, input int addr_w);
        return (byte_addr >> 2) & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/scc_mem_clear_seq.sv
// rtl/scc_mem_clear_seq.sv - post-reset clear sequencer: owns CLEAR/RUN state, clear counter and mem_busy
module scc_mem_clear_seq
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int CLR_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_busy,
    output logic              run,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    mem_state_e        state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_en     = 1'b0;
        case (state)
            CLEAR: begin
                clr_en   = 1'b1;
                cnt_next = cnt + ADDR_W'(CLR_PER_CYC);
                // The block of words written this cycle ends at the top of the array.
                if (cnt == ADDR_W'(DEPTH - CLR_PER_CYC)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: state_next = CLEAR;
        endcase
    end

    assign clr_addr = cnt;
    assign mem_busy = (state == CLEAR);
    assign run      = (state == RUN);

endmodule

// File: rtl/scc_unified_mem.sv
// rtl/scc_unified_mem.sv - shared instruction/data word memory for the SCC core
// Optional access checking (misaligned / out-of-range) enabled by SCC_MEM_ERRCHK_EN.
module scc_unified_mem
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int CLR_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in_mem_addr,
    input  logic              in_mem_en,
    output logic [WORD_W-1:0] in_mem,
    input  logic [31:0]       data_addr,
    input  logic [WORD_W-1:0] data_out,
    input  logic              data_read,
    input  logic              data_write,
    output logic [WORD_W-1:0] data_in,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic              run;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] i_idx, d_idx;
    logic              i_fault, d_fault;
    logic              wr_en;

    scc_mem_clear_seq #(
        .ADDR_W      (ADDR_W),
        .CLR_PER_CYC (CLR_PER_CYC)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .mem_busy (mem_busy),
        .run      (run),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign i_idx = ADDR_W'(word_index(in_mem_addr, ADDR_W));
    assign d_idx = ADDR_W'(word_index(data_addr, ADDR_W));

`ifdef SCC_MEM_ERRCHK_EN
    assign i_fault = (in_mem_addr[1:0] != 2'b00) || ((in_mem_addr >> (ADDR_W + 2)) != 32'd0);
    assign d_fault = (data_addr[1:0] != 2'b00) || ((data_addr >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else if (run && ((in_mem_en && i_fault) || ((data_read || data_write) && d_fault))) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign i_fault = 1'b0;
    assign d_fault = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign wr_en = run && data_write && !d_fault;

    // Array has no reset of its own; the clear sequencer zeroes it. A write on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_en) begin
                for (int k = 0; k < CLR_PER_CYC; k++) begin
                    mem[clr_addr + ADDR_W'(k)] <= '0;
                end
            end else if (wr_en) begin
                mem[d_idx] <= data_out;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_mem  <= '0;
            data_in <= '0;
        end else if (run) begin
            if (in_mem_en) begin
                in_mem <= i_fault ? '0 : ((wr_en && (d_idx == i_idx)) ? data_out : mem[i_idx]);
            end
            if (data_read) begin
                data_in <= d_fault ? '0 : (wr_en ? data_out : mem[d_idx]);
            end
        end
    end

endmodule

// File: tb/tb_scc_unified_mem.sv
// tb/tb_scc_unified_mem.sv - randomized self-checking bench for scc_unified_mem
module tb_scc_unified_mem;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_mem_addr, data_addr, data_out, in_mem, data_in;
    logic        in_mem_en, data_read, data_write, mem_busy, mem_err;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_in, exp_din;
    logic        exp_err;

    always #5 clk = ~clk;

    scc_unified_mem #(.ADDR_W(AW), .CLR_PER_CYC(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_mem_addr (in_mem_addr),
        .in_mem_en   (in_mem_en),
        .in_mem      (in_mem),
        .data_addr   (data_addr),
        .data_out    (data_out),
        .data_read   (data_read),
        .data_write  (data_write),
        .data_in     (data_in),
        .mem_busy    (mem_busy),
        .mem_err     (mem_err)
    );

    function automatic bit is_fault(input logic [31:0] a);
`ifdef SCC_MEM_ERRCHK_EN
        return (a % 4 != 0) || (a >= 4 * DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic idle();
        in_mem_en   = 1'b0;
        in_mem_addr = '0;
        data_read   = 1'b0;
        data_write  = 1'b0;
        data_addr   = '0;
        data_out    = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_in  = '0;
        exp_din = '0;
        exp_err = 1'b0;
    endtask

    // One RUN-state cycle: drive the request, advance the model, sample after the edge.
    task automatic step(input bit fen, input logic [31:0] fa, input bit rd, input bit wr,
                        input logic [31:0] da, input logic [31:0] wd);
        bit iflt, dflt, wok;
        in_mem_en   = fen;
        in_mem_addr = fa;
        data_read   = rd;
        data_write  = wr;
        data_addr   = da;
        data_out    = wd;
        iflt = is_fault(fa);
        dflt = is_fault(da);
        wok  = wr && !dflt;
        if (fen) exp_in  = iflt ? 32'd0 : ((wok && widx(fa) == widx(da)) ? wd : model[widx(fa)]);
        if (rd)  exp_din = dflt ? 32'd0 : (wok ? wd : model[widx(da)]);
        if (wok) model[widx(da)] = wd;
        if ((fen && iflt) || ((rd || wr) && dflt)) exp_err = 1'b1;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (!mem_busy) break;
        end
        vectors++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL %s: busy cycles actual=%0d required=%0d", name, n, DEPTH);
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        model_reset();
        #1;
        vectors += 4;
        if (in_mem !== 32'd0)  begin errors++; $display("FAIL reset_in_mem: actual=%h required=0", in_mem); end
        if (data_in !== 32'd0) begin errors++; $display("FAIL reset_data_in: actual=%h required=0", data_in); end
        if (mem_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: actual=%b required=1", mem_busy); end
        if (mem_err !== 1'b0)  begin errors++; $display("FAIL reset_err: actual=%b required=0", mem_err); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_busy("initial_clear");
    endtask

    task automatic test_clear_zero();
        for (int a = 0; a < 4 * DEPTH; a += 4) begin
            step(1'b1, a, 1'b1, 1'b0, a, 32'd0);
            vectors += 2;
            if (data_in !== 32'd0) begin errors++; $display("FAIL zero_read @%h: actual=%h required=0", a, data_in); end
            if (in_mem !== 32'd0)  begin errors++; $display("FAIL zero_fetch @%h: actual=%h required=0", a, in_mem); end
        end
    endtask

    task automatic test_store_load();
        step(1'b0, 0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        step(1'b0, 0, 1'b1, 1'b0, 32'h10, 32'd0);
        vectors++;
        if (data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL store_load: actual=%h required=deadbeef", data_in); end
        step(1'b0, 0, 1'b0, 1'b0, 32'h00, 32'd0);
        vectors++;
        if (data_in !== 32'hDEADBEEF) begin errors++; $display("FAIL data_in_hold: actual=%h required=deadbeef", data_in); end
    endtask

    task automatic test_forwarding();
        step(1'b1, 32'h20, 1'b0, 1'b1, 32'h20, 32'h12345678);
        vectors++;
        if (in_mem !== 32'h12345678) begin errors++; $display("FAIL fetch_fwd: actual=%h required=12345678", in_mem); end
        step(1'b0, 0, 1'b1, 1'b1, 32'h24, 32'hA5A5A5A5);
        vectors++;
        if (data_in !== 32'hA5A5A5A5) begin errors++; $display("FAIL rw_fwd: actual=%h required=a5a5a5a5", data_in); end
        step(1'b1, 32'h24, 1'b0, 1'b0, 0, 0);
        vectors++;
        if (in_mem !== 32'hA5A5A5A5) begin errors++; $display("FAIL fetch_after_rw: actual=%h required=a5a5a5a5", in_mem); end
        step(1'b0, 32'h00, 1'b0, 1'b0, 0, 0);
        vectors++;
        if (in_mem !== 32'hA5A5A5A5) begin errors++; $display("FAIL in_mem_hold: actual=%h required=a5a5a5a5", in_mem); end
    endtask

    task automatic test_mid_clear_reset();
        step(1'b0, 0, 1'b0, 1'b1, 32'h08, 32'hCAFEF00D);
        step(1'b0, 0, 1'b0, 1'b1, 32'h3C, 32'h0BADF00D);
        reset = 1'b1;
        #1;
        vectors++;
        if (in_mem !== 32'd0 || data_in !== 32'd0 || mem_busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: in_mem=%h data_in=%h busy=%b required 0/0/1", in_mem, data_in, mem_busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Requests during CLEAR must be ignored entirely.
        in_mem_en   = 1'b1;
        in_mem_addr = 32'h00;
        data_read   = 1'b1;
        data_write  = 1'b1;
        data_addr   = 32'h00;
        data_out    = 32'hFFFFFFFF;
        count_busy("restart_clear");
        idle();
        vectors += 2;
        if (in_mem !== 32'd0 || data_in !== 32'd0) begin
            errors++;
            $display("FAIL clear_ignores_req: in_mem=%h data_in=%h required 0/0", in_mem, data_in);
        end
        if (mem_err !== 1'b0) begin errors++; $display("FAIL clear_no_err: actual=%b required=0", mem_err); end
        foreach (model[i]) begin
            step(1'b0, 0, 1'b1, 1'b0, 32'(i * 4), 0);
            vectors++;
            if (data_in !== 32'd0) begin errors++; $display("FAIL cleared_word %0d: actual=%h required=0", i, data_in); end
        end
    endtask

`ifdef SCC_MEM_ERRCHK_EN
    task automatic test_errchk();
        step(1'b0, 0, 1'b0, 1'b1, 32'h00, 32'h55555555);
        vectors++;
        if (mem_err !== 1'b0) begin errors++; $display("FAIL err_clean: actual=%b required=0", mem_err); end
        step(1'b0, 0, 1'b0, 1'b1, 32'h13, 32'h77777777);
        vectors++;
        if (mem_err !== 1'b1) begin errors++; $display("FAIL err_misaligned: actual=%b required=1", mem_err); end
        step(1'b0, 0, 1'b1, 1'b0, 32'h10, 0);
        vectors++;
        if (data_in !== 32'd0) begin errors++; $display("FAIL err_write_dropped: actual=%h required=0", data_in); end
        step(1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 0);
        vectors += 3;
        if (data_in !== 32'd0) begin errors++; $display("FAIL err_oor_read: actual=%h required=0", data_in); end
        if (in_mem !== 32'd0)  begin errors++; $display("FAIL err_oor_fetch: actual=%h required=0", in_mem); end
        if (mem_err !== 1'b1)  begin errors++; $display("FAIL err_sticky: actual=%b required=1", mem_err); end
    endtask
`else
    task automatic test_wrap();
        step(1'b0, 0, 1'b0, 1'b1, 32'h1004, 32'h11111111);
        step(1'b1, 32'h2007, 1'b1, 1'b0, 32'h0004, 0);
        vectors += 3;
        if (data_in !== 32'h11111111) begin errors++; $display("FAIL wrap_read: actual=%h required=11111111", data_in); end
        if (in_mem !== 32'h11111111)  begin errors++; $display("FAIL wrap_fetch: actual=%h required=11111111", in_mem); end
        if (mem_err !== 1'b0)         begin errors++; $display("FAIL wrap_no_err: actual=%b required=0", mem_err); end
    endtask
`endif

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom();
        return 32'($urandom_range(0, DEPTH - 1) * 4);
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            vectors += 3;
            if (in_mem !== exp_in)   begin errors++; $display("FAIL rand_in_mem cyc %0d: actual=%h required=%h", c, in_mem, exp_in); end
            if (data_in !== exp_din) begin errors++; $display("FAIL rand_data_in cyc %0d: actual=%h required=%h", c, data_in, exp_din); end
            if (mem_err !== exp_err) begin errors++; $display("FAIL rand_err cyc %0d: actual=%b required=%b", c, mem_err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_clear_zero();
        test_store_load();
        test_forwarding();
        test_mid_clear_reset();
`ifdef SCC_MEM_ERRCHK_EN
        test_errchk();
`else
        test_wrap();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/scc_unified_mem.md
Name: scc_unified_mem

Overview:
- Responder-side memory for the SCC core; serves both the instruction-fetch port and the data load/store port from one word array.
- Port names mirror the core's signals, so the two blocks connect by name at the top level.
- After reset, an internal clear sequencer zeroes the array before the block accepts any request.
- Reads are registered (1-cycle latency). Writes use write-first forwarding.

Parameters:
- ADDR_W, 10: word-index width; depth = 2**ADDR_W words (4 KiB by default).
- CLR_PER_CYC, 1: words zeroed per cycle during CLEAR; legal values are 1, 2, 4; must divide the depth.

Ports:
- clk  input  1  main clock
- reset  input  1  asynchronous, active-high; puts all regs in a known state
- in_mem_addr  input  32  byte address of the instruction fetch
- in_mem_en  input  1  fetch request
- in_mem  output  32  fetched instruction; valid the cycle after in_mem_en
- data_addr  input  32  byte address of the load/store
- data_out  input  32  store data from the core
- data_read  input  1  load request
- data_write  input  1  store request
- data_in  output  32  load data to the core; valid the cycle after data_read
- mem_busy  output  1  high while CLEAR runs; the core must stall fetch
- mem_err  output  1  sticky access-error flag (see Optional Feature)

Behaviour:
- Reset values:
  - in_mem = 0, data_in = 0, mem_busy = 1, mem_err = 0.
  - State = CLEAR, clear counter = 0.
  - Array contents are not reset directly; the CLEAR state zeroes them.
- States:
  - CLEAR:
    - Each cycle, write 0 to CLR_PER_CYC words starting at the counter; the counter advances by CLR_PER_CYC.
    - After the last word is written, go to RUN on the next edge. mem_busy falls on the same edge.
    - All requests are ignored: no writes, no errors, in_mem/data_in held at 0.
  - RUN: normal service. There is no path back to CLEAR except reset.
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - Bits [1:0] and bits above ADDR_W+1 are handled per the Optional Feature.
- Instruction port (RUN):
  - in_mem_en = 1 at edge N registers array[index]; the value appears on in_mem after edge N.
  - in_mem_en = 0: in_mem holds its last value.
- Data read (RUN): same timing as the instruction port, on data_in. data_read = 0 holds data_in.
- Data write (RUN): data_write = 1 at edge N writes data_out into array[index] at edge N.
- Simultaneous events:
  - data_read and data_write both high: the write is performed and data_in returns the newly written data_out.
  - Data write and instruction fetch to the same index in the same cycle: in_mem returns the new data (write-first forwarding).
  - Fetch and read of the same or different indices in one cycle are both served; there is no arbitration.
- Reset mid-operation:
  - Asynchronous assert immediately forces the reset values.
  - A clear in progress restarts at index 0.
  - A write on the edge coinciding with reset assertion is dropped.
- Clear duration = 2**ADDR_W / CLR_PER_CYC cycles. Default: 1024 cycles.

Optional Feature:
- Macro: SCC_MEM_ERRCHK_EN.
- Defined:
  - Misaligned access (addr[1:0] != 0) or out-of-range access (any bit above ADDR_W+1 set) on any active request in RUN sets mem_err on the next edge.
  - mem_err stays high until reset.
  - A faulting write is dropped.
  - A faulting read returns 0 on in_mem/data_in with the normal 1-cycle latency.
- Not defined:
  - Upper and low address bits are ignored, so addresses wrap modulo 4·2**ADDR_W.
  - mem_err is tied to 0.
  - No request is ever dropped.

Decomposition:
- Package scc_mem_pkg holds:
  - the state enum (CLEAR, RUN)
  - WORD_W = 32
  - the default ADDR_W
  - the function that extracts the word index from a byte address
- One natural sub-module: scc_mem_clear_seq. It owns the clear counter, the state, and mem_busy, and supplies clear-write address/enable to the array.

Test Plan:
- Release reset with ADDR_W=4, CLR_PER_CYC=1 -> mem_busy high for exactly 16 cycles; afterwards a data_read of every address 0x00..0x3C returns 0.
- Store 0xDEADBEEF to 0x10, then load 0x10 the next cycle -> data_in = 0xDEADBEEF one cycle after data_read.
- Same cycle: data_write 0x12345678 to 0x20 plus in_mem_en at 0x20 -> in_mem = 0x12345678 next cycle; data_read and data_write together at 0x24 with 0xA5A5A5A5 -> data_in = 0xA5A5A5A5.
- Assert reset for 1 cycle midway through CLEAR (counter = 8) -> mem_busy stays high for a full 16 further cycles; words previously stored read as 0.
- SCC_MEM_ERRCHK_EN defined: store to 0x13 -> mem_err = 1 next edge, array unchanged; load 0x4000 (ADDR_W=10) -> data_in = 0.
- SCC_MEM_ERRCHK_EN not defined: store 0x11111111 to 0x1004 (ADDR_W=10) -> load 0x0004 returns 0x11111111; mem_err stays 0.
